// File: rtl/mod3_reduce_seq_if.sv
// ---------------------------------------------------------------------------
// mod3_reduce_seq_if: control, source-read and destination-write bus. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mod3_reduce_seq_if #(
  parameter int SRC_AW = 10,
  parameter int DST_AW = 8
);
  logic              start;
  logic              hold;
  logic              busy;
  logic              done;
  logic              src_rd;
  logic [SRC_AW-1:0] src_addr;
  logic [7:0]        src_data;
  logic              dst_we;
  logic [DST_AW-1:0] dst_addr;
  logic [7:0]        dst_data;

  modport master (
    input  start, hold, src_data,
    output busy, done, src_rd, src_addr, dst_we, dst_addr, dst_data
  );

  modport slave (
    output start, hold, src_data,
    input  busy, done, src_rd, src_addr, dst_we, dst_addr, dst_data
  );
endinterface

`default_nettype wire

// File: rtl/mod3_reduce_seq.sv
// ---------------------------------------------------------------------------
// mod3_reduce_seq: byte coefficients -> mod-3 trits, packed four per byte. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mod3_reduce_seq #(
  parameter int N      = 701,
  parameter int SRC_AW = 10,
  parameter int DST_AW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mod3_reduce_seq_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [SRC_AW-1:0] LAST_IDX = SRC_AW'(N - 1);

  // 4^k == 1 (mod 3), so summing the 2-bit digits preserves the residue.
  function automatic logic [1:0] mod3_byte(input logic [7:0] b);
    logic [3:0] s4;
    logic [2:0] s3;
    logic [1:0] s2;
    s4 = 4'(b[1:0]) + 4'(b[3:2]) + 4'(b[5:4]) + 4'(b[7:6]);
    s3 = 3'(s4[3:2]) + 3'(s4[1:0]);
    s2 = 2'(s3[2]) + s3[1:0];
    return (s2 == 2'd3) ? 2'd0 : s2;
  endfunction

  state_t            state_q, state_d;
  logic [SRC_AW-1:0] rc_q, rc_d;
  logic [SRC_AW-1:0] wc_q, wc_d;
  logic [7:0]        pack_q, pack_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              src_rd_q, src_rd_d;
  logic [SRC_AW-1:0] src_addr_q, src_addr_d;
  logic              dst_we_q, dst_we_d;
  logic [DST_AW-1:0] dst_addr_q, dst_addr_d;
  logic [7:0]        dst_data_q, dst_data_d;

  logic [1:0]        trit;
  logic [7:0]        pack_next;
  logic              word_end;
  logic              last_in;

  always_comb begin
    trit      = mod3_byte(bus.src_data);
    pack_next = pack_q | (8'(trit) << {wc_q[1:0], 1'b0});
    last_in   = vld_q && (wc_q == LAST_IDX);
    word_end  = (wc_q[1:0] == 2'd3) || (wc_q == LAST_IDX);
  end

  always_comb begin
    state_d    = state_q;
    rc_d       = rc_q;
    wc_d       = wc_q;
    pack_d     = pack_q;
    vld_d      = src_rd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    src_rd_d   = 1'b0;
    src_addr_d = src_addr_q;
    dst_we_d   = 1'b0;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;

    // Write side runs off the returned-data valid, independent of the read side.
    if (vld_q) begin
      wc_d = wc_q + SRC_AW'(1);
      if (word_end) begin
        dst_we_d   = 1'b1;
        dst_addr_d = DST_AW'(wc_q[SRC_AW-1:2]);
        dst_data_d = pack_next;
        pack_d     = 8'd0;
      end else begin
        pack_d = pack_next;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // The first read leaves with the accept so cycle 1 already reads index 0.
          state_d    = (N == 1) ? DRAIN : ISSUE;
          src_rd_d   = 1'b1;
          src_addr_d = '0;
          rc_d       = SRC_AW'(1);
          wc_d       = '0;
          pack_d     = 8'd0;
          busy_d     = 1'b1;
        end
      end
      ISSUE: begin
        if (!bus.hold) begin
          src_rd_d   = 1'b1;
          src_addr_d = rc_q;
          rc_d       = rc_q + SRC_AW'(1);
          if (rc_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_in) begin
          state_d = FIN;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rc_q       <= '0;
      wc_q       <= '0;
      pack_q     <= 8'd0;
      vld_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      src_rd_q   <= 1'b0;
      src_addr_q <= '0;
      dst_we_q   <= 1'b0;
      dst_addr_q <= '0;
      dst_data_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      rc_q       <= rc_d;
      wc_q       <= wc_d;
      pack_q     <= pack_d;
      vld_q      <= vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      src_rd_q   <= src_rd_d;
      src_addr_q <= src_addr_d;
      dst_we_q   <= dst_we_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.src_rd   = src_rd_q;
  assign bus.src_addr = src_addr_q;
  assign bus.dst_we   = dst_we_q;
  assign bus.dst_addr = dst_addr_q;
  assign bus.dst_data = dst_data_q;

endmodule

`default_nettype wire
